ulx3s_pll_supervisor: RTL and testbench
=======================================

# ulx3s_pll_supervisor

Parametrised PLL lock supervisor and reset sequencer for ULX3S designs, running on the 25 MHz board clock next to the ECP5 EHXPLLL clock generator. It drives the PLL's RST input, filters and monitors the PLL LOCK output, and recovers from lock timeouts with a bounded number of retries. It releases CHANNELS active-low reset outputs in a staggered order once lock is stable, and pulls every reset back low immediately if lock is lost. Each downstream clock domain re-synchronises its own rst_n_out bit.

## Interface
Parameters:
- CHANNELS, 4, number of sequenced reset outputs (1..16)
- PLLRST_CYCLES, 16, cycles pll_rst is held high per reset attempt (≥1)
- LOCK_FILTER, 1024, consecutive synchronised-locked cycles required before release (≥1)
- LOCK_TIMEOUT, 1048576, cycles allowed from pll_rst deassertion to filter satisfied (> LOCK_FILTER)
- STAGGER, 256, cycles between successive channel releases (≥1)
- MAX_RETRIES, 3, timeout retries before FAULT (≥0)

Ports:
- clkin  in  1  25 MHz board clock; the only clock
- resetn  in  1  asynchronous, active-low reset
- locked  in  1  PLL LOCK; asynchronous, synchronised internally
- force_relock  in  1  synchronous request to restart the full sequence
- pll_rst  out  1  active-high PLL reset
- rst_n_out  out  CHANNELS  per-domain active-low resets; bit 0 is released first
- ready  out  1  high while in RUN
- fault  out  1  high while in FAULT
- lock_lost  out  1  one-cycle pulse when lock drops during RELEASE or RUN
- retry_count  out  clog2(MAX_RETRIES+1), min 1  timeouts since last RUN or force_relock

## Operation
- States: PLL_RESET, WAIT_LOCK, FILTER, RELEASE, RUN, FAULT.
- locked_s is `locked` after a 2-flop synchroniser.
- PLL_RESET
  - pll_rst=1 and all rst_n_out=0.
  - After PLLRST_CYCLES cycles, go to WAIT_LOCK and clear the timeout counter.
- WAIT_LOCK
  - The timeout counter runs.
  - locked_s=1 goes to FILTER.
- FILTER
  - The filter counter counts consecutive locked_s=1 cycles.
  - locked_s=0 clears the filter counter and returns to WAIT_LOCK. The timeout counter is not cleared.
  - Filter count reaching LOCK_FILTER goes to RELEASE.
- Timeout, in WAIT_LOCK or FILTER:
  - When the timeout counter reaches LOCK_TIMEOUT and retry_count < MAX_RETRIES: retry_count+1, go to PLL_RESET.
  - Otherwise go to FAULT.
- RELEASE
  - The stagger counter runs.
  - rst_n_out[k] rises STAGGER·(k+1) cycles after RELEASE entry and then stays high.
  - The cycle bit CHANNELS-1 rises, go to RUN and clear retry_count.
- RUN: ready=1 and all rst_n_out=1.
- Lock loss: locked_s=0 in RELEASE or RUN
  - Next cycle: all rst_n_out=0, ready=0, lock_lost=1 for one cycle, state PLL_RESET.
  - retry_count is unchanged.
- FAULT
  - pll_rst=0, all rst_n_out=0, fault=1.
  - FAULT is left only by resetn or force_relock.
- force_relock
  - Highest priority, valid in any state.
  - Next cycle: PLL_RESET, retry_count=0, all counters cleared, all rst_n_out=0.
  - lock_lost is not pulsed.
- Simultaneous events: force_relock beats lock loss, which beats timeout, which beats normal progression.
- All outputs are registered.

## Timing
- Reset values:
  - pll_rst=1, state PLL_RESET, counters 0.
  - rst_n_out=all 0, ready=0, fault=0, lock_lost=0, retry_count=0.
  - Synchroniser flops 0.
- A locked edge takes 2 cycles to reach locked_s. Lock loss takes 3 cycles from `locked` falling to rst_n_out low.
- Best case, from resetn deassertion to ready: PLLRST_CYCLES + 2 + LOCK_FILTER + STAGGER·CHANNELS cycles, plus one cycle per state transition. The bench checks against a model with this exact accounting.
- Counter widths:
  - Each counter is sized clog2(limit+1).
  - The timeout counter saturates and never wraps.
- resetn assertion mid-sequence asynchronously restores all reset values, including pll_rst=1.
- force_relock held high keeps the block in PLL_RESET with pll_rst=1.

## Structure
- Package ulx3s_pll_supervisor_pkg holds:
  - the state enum;
  - a clog2 helper;
  - the priority ordering constants.
- Sub-module ulx3s_sync2: a 2-flop synchroniser with asynchronous active-low reset, used for `locked`.
- Counters and the FSM are inline in the top module.

## Test plan
All scenarios use CHANNELS=3, PLLRST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=64, STAGGER=5, MAX_RETRIES=2.
- Clean start: `locked` rises 10 cycles after pll_rst falls.
  - rst_n_out bits rise 5 cycles apart in order 0,1,2.
  - ready rises with bit 2; retry_count=0.
- Glitchy lock: `locked` toggles 1 for 5 cycles, 0, then 1 steady.
  - The filter restarts.
  - Release starts 8 locked_s cycles after the last rise.
  - No timeout.
- Timeout then recovery: `locked` stuck at 0 through 2 attempts, then rises.
  - retry_count goes 1 then 2.
  - After release and RUN, retry_count=0.
- Fault: `locked` stuck at 0.
  - Three timeouts lead to FAULT: fault=1, pll_rst=0, rst_n_out=000.
  - force_relock leads to PLL_RESET with retry_count=0.
- Lock loss in RUN: drop `locked` for 1 cycle.
  - Exactly one lock_lost pulse.
  - rst_n_out=000 three cycles after the drop.
  - pll_rst=1 for 4 cycles, then a full re-sequence.
- Async reset mid-RELEASE, after bit 0 has been released: assert resetn low.
  - All outputs take their reset values in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/ulx3s_pll_supervisor_pkg.sv
// Shared types and helpers for the ULX3S PLL lock supervisor.
package ulx3s_pll_supervisor_pkg;

    // Sequencer states, also exported on the debug state port.
    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } sup_state_e;

    // Competing events in one cycle; a lower encoding wins.
    // Order: force_relock, lock loss, timeout, then normal progression.
    typedef enum logic [1:0] {
        EV_FORCE     = 2'd0,
        EV_LOCK_LOSS = 2'd1,
        EV_TIMEOUT   = 2'd2,
        EV_NONE      = 2'd3
    } sup_event_e;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a counter that must hold 0..limit, never narrower than one bit.
    function automatic int cnt_width(input int limit);
        int w;
        w = clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Resolve simultaneous events into the single one that takes effect.
    function automatic sup_event_e pick_event(input logic force_req,
                                              input logic lock_loss,
                                              input logic timeout);
        if (force_req) begin
            return EV_FORCE;
        end
        if (lock_loss) begin
            return EV_LOCK_LOSS;
        end
        if (timeout) begin
            return EV_TIMEOUT;
        end
        return EV_NONE;
    endfunction

endpackage

// File: rtl/ulx3s_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module ulx3s_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Capture the asynchronous level, then re-time it once more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ulx3s_pll_supervisor.sv
// PLL lock supervisor and staggered reset sequencer on the 25 MHz board clock.
// Drives the PLL reset, filters LOCK, retries on timeout and releases the
// downstream resets one channel at a time once lock is stable.
module ulx3s_pll_supervisor
    import ulx3s_pll_supervisor_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int PLLRST_CYCLES = 16,
    parameter int LOCK_FILTER   = 1024,
    parameter int LOCK_TIMEOUT  = 1048576,
    parameter int STAGGER       = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                              clkin,
    input  logic                              resetn,
    input  logic                              locked,
    input  logic                              force_relock,
    output logic                              pll_rst,
    output logic [CHANNELS-1:0]               rst_n_out,
    output logic                              ready,
    output logic                              fault,
    output logic                              lock_lost,
    output logic [cnt_width(MAX_RETRIES)-1:0] retry_count,
    output sup_state_e                        state_dbg
);

    localparam int STG_LIMIT = STAGGER * CHANNELS;
    localparam int RST_W     = cnt_width(PLLRST_CYCLES);
    localparam int FLT_W     = cnt_width(LOCK_FILTER);
    localparam int TMO_W     = cnt_width(LOCK_TIMEOUT);
    localparam int STG_W     = cnt_width(STG_LIMIT);
    localparam int RTY_W     = cnt_width(MAX_RETRIES);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLLRST_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(LOCK_TIMEOUT);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STG_LIMIT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    // force_relock is a level request rather than a handshake: every cycle it
    // is sampled high restarts the sequence, so holding it parks the block in
    // PLL_RESET with the PLL held in reset.

    logic                locked_s;
    sup_state_e          state_q, state_d;
    logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [FLT_W-1:0]    flt_cnt_q, flt_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [STG_W-1:0]    stg_cnt_q, stg_cnt_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic                pll_rst_q, pll_rst_d;
    logic [CHANNELS-1:0] rst_n_q, rst_n_d;
    logic                ready_q, ready_d;
    logic                fault_q, fault_d;
    logic                lock_lost_q, lock_lost_d;
    logic                lock_loss;
    logic                timeout_hit;
    logic [TMO_W-1:0]    tmo_inc;
    sup_event_e          ev;

    ulx3s_sync2 u_lock_sync (
        .clk   (clkin),
        .rst_n (resetn),
        .d     (locked),
        .q     (locked_s)
    );

    // Next-state, counter and registered-output computation.
    always_comb begin
        lock_loss   = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !locked_s;
        timeout_hit = ((state_q == ST_WAIT_LOCK) || (state_q == ST_FILTER)) &&
                      (tmo_cnt_q >= TMO_LAST);
        tmo_inc     = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        ev          = pick_event(force_relock, lock_loss, timeout_hit);

        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        flt_cnt_d   = flt_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        stg_cnt_d   = stg_cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        case (ev)
            EV_FORCE: begin
                state_d   = ST_PLL_RESET;
                rst_cnt_d = '0;
                flt_cnt_d = '0;
                tmo_cnt_d = '0;
                stg_cnt_d = '0;
                retry_d   = '0;
            end
            EV_LOCK_LOSS: begin
                state_d     = ST_PLL_RESET;
                rst_cnt_d   = '0;
                flt_cnt_d   = '0;
                stg_cnt_d   = '0;
                lock_lost_d = 1'b1;
            end
            EV_TIMEOUT: begin
                flt_cnt_d = '0;
                if (retry_q < RTY_MAX) begin
                    retry_d   = retry_q + 1'b1;
                    state_d   = ST_PLL_RESET;
                    rst_cnt_d = '0;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                case (state_q)
                    ST_PLL_RESET: begin
                        if (rst_cnt_q == RST_LAST) begin
                            state_d   = ST_WAIT_LOCK;
                            rst_cnt_d = '0;
                            tmo_cnt_d = '0;
                        end else begin
                            rst_cnt_d = rst_cnt_q + 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        tmo_cnt_d = tmo_inc;
                        if (locked_s) begin
                            state_d   = ST_FILTER;
                            flt_cnt_d = '0;
                        end
                    end
                    ST_FILTER: begin
                        // The timeout keeps running across filter restarts.
                        tmo_cnt_d = tmo_inc;
                        if (!locked_s) begin
                            state_d   = ST_WAIT_LOCK;
                            flt_cnt_d = '0;
                        end else if (flt_cnt_q == FLT_LAST) begin
                            state_d   = ST_RELEASE;
                            flt_cnt_d = '0;
                            stg_cnt_d = '0;
                        end else begin
                            flt_cnt_d = flt_cnt_q + 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        if (stg_cnt_q == STG_LAST) begin
                            state_d   = ST_RUN;
                            stg_cnt_d = '0;
                            retry_d   = '0;
                        end else begin
                            stg_cnt_d = stg_cnt_q + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        state_d = ST_RUN;
                    end
                    ST_FAULT: begin
                        state_d = ST_FAULT;
                    end
                    default: begin
                        state_d   = ST_PLL_RESET;
                        rst_cnt_d = '0;
                    end
                endcase
            end
        endcase

        // Outputs follow the next state so they change on the same edge.
        pll_rst_d = (state_d == ST_PLL_RESET);
        ready_d   = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
        rst_n_d   = '0;
        if (state_d == ST_RUN) begin
            rst_n_d = '1;
        end else if (state_d == ST_RELEASE) begin
            for (int k = 0; k < CHANNELS; k++) begin
                rst_n_d[k] = (stg_cnt_d >= STG_W'(STAGGER * (k + 1)));
            end
        end
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_PLL_RESET;
            rst_cnt_q   <= '0;
            flt_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            stg_cnt_q   <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            rst_n_q     <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            flt_cnt_q   <= flt_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            stg_cnt_q   <= stg_cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            rst_n_q     <= rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign rst_n_out   = rst_n_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign lock_lost   = lock_lost_q;
    assign retry_count = retry_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ulx3s_pll_supervisor.sv
// Self-checking bench for ulx3s_pll_supervisor: scenario tasks compare every
// cycle against an event-timing model derived from the sequencing rules.
module tb_ulx3s_pll_supervisor;
    import ulx3s_pll_supervisor_pkg::*;

    localparam int CH = 3;
    localparam int PR = 4;
    localparam int LF = 8;
    localparam int LT = 64;
    localparam int ST = 5;
    localparam int MR = 2;

    localparam logic [8:0] RESET_VEC = 9'b1_000_0_0_0_00;

    logic          clkin;
    logic          resetn;
    logic          locked;
    logic          force_relock;
    logic          pll_rst;
    logic [CH-1:0] rst_n_out;
    logic          ready;
    logic          fault;
    logic          lock_lost;
    logic [1:0]    retry_count;
    sup_state_e    state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    ulx3s_pll_supervisor #(
        .CHANNELS      (CH),
        .PLLRST_CYCLES (PR),
        .LOCK_FILTER   (LF),
        .LOCK_TIMEOUT  (LT),
        .STAGGER       (ST),
        .MAX_RETRIES   (MR)
    ) dut (
        .clkin        (clkin),
        .resetn       (resetn),
        .locked       (locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .rst_n_out    (rst_n_out),
        .ready        (ready),
        .fault        (fault),
        .lock_lost    (lock_lost),
        .retry_count  (retry_count),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clkin = 1'b0;
    always #20 clkin = ~clkin;
    always @(posedge clkin) edge_n <= edge_n + 1;

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    // Observed output vector {pll_rst, rst_n_out, ready, fault, lock_lost, retry}.
    function automatic logic [8:0] outs();
        return {pll_rst, rst_n_out, ready, fault, lock_lost, retry_count};
    endfunction

    // ---------------- reference model ----------------
    // Edge at which RELEASE begins: the first WAIT_LOCK cycle that sees the
    // synchronised lock (two cycles after the input rises), one cycle to move
    // into FILTER, then LOCK_FILTER locked cycles.
    function automatic int model_release(input int last_rise, input int wait_edge);
        int seen;
        seen = (last_rise + 2 > wait_edge) ? last_rise + 2 : wait_edge;
        return seen + 1 + LF;
    endfunction

    // Expected outputs in cycle e of an attempt that entered PLL_RESET at p,
    // WAIT_LOCK at w and RELEASE at r (r < 0: no release in view).
    function automatic logic [8:0] model_seq(input int e, input int p, input int w,
                                             input int r, input int rty);
        logic [CH-1:0] rst;
        logic          rdy;
        rst = '0;
        for (int k = 0; k < CH; k++) begin
            rst[k] = (r >= 0) && (e >= r + ST * (k + 1));
        end
        rdy = (r >= 0) && (e >= r + ST * CH);
        return {(e >= p) && (e < w), rst, rdy, 1'b0, 1'b0, rdy ? 2'd0 : 2'(rty)};
    endfunction

    // ---------------- drivers ----------------
    // Apply reset and release it mid-cycle; base is the cycle of release.
    task automatic do_reset(output int base);
        resetn       = 1'b0;
        locked       = 1'b0;
        force_relock = 1'b0;
        repeat (3) @(negedge clkin);
        resetn = 1'b1;
        base   = edge_n;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [8:0] got;
        resetn       = 1'b0;
        force_relock = 1'b0;
        locked       = 1'($urandom_range(0, 1));
        repeat (3) @(negedge clkin);
        got = outs();
        n_cmp++;
        if (got !== RESET_VEC) begin
            n_bad++;
            $display("FAIL reset_values: got %b expected %b", got, RESET_VEC);
        end
        n_cmp++;
        if (state_dbg !== ST_PLL_RESET) begin
            n_bad++;
            $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_PLL_RESET);
        end
    endtask

    task automatic test_clean_start();
        int b, w, e_lock, r, rdy;
        logic [8:0] got, exp;
        do_reset(b);
        w      = b + PR;
        e_lock = w + 10;
        r      = model_release(e_lock, w);
        rdy    = r + ST * CH;
        for (int e = b; e <= rdy + 3; e++) begin
            got = outs();
            exp = model_seq(e, b, w, r, 0);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL clean_start c%0d: got %b expected %b", e - b, got, exp);
            end
            if (e == e_lock) locked = 1'b1;
            @(negedge clkin);
        end
    endtask

    task automatic test_glitchy_lock();
        int b, w, a, r, rdy;
        logic [8:0] got, exp;
        do_reset(b);
        w   = b + PR;
        a   = w + $urandom_range(0, 10);
        r   = model_release(a + 6, w);
        rdy = r + ST * CH;
        for (int e = b; e <= rdy + 2; e++) begin
            got = outs();
            exp = model_seq(e, b, w, r, 0);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL glitchy_lock c%0d: got %b expected %b", e - b, got, exp);
            end
            if (e == a)     locked = 1'b1;
            if (e == a + 5) locked = 1'b0;
            if (e == a + 6) locked = 1'b1;
            @(negedge clkin);
        end
    endtask

    task automatic test_timeout_recovery();
        int b, e_lock, r, rdy, i;
        int p[3];
        int w[3];
        logic [8:0] got, exp;
        do_reset(b);
        for (int k = 0; k < 3; k++) begin
            p[k] = b + k * (PR + LT);
            w[k] = p[k] + PR;
        end
        e_lock = w[2] + $urandom_range(0, 30);
        r      = model_release(e_lock, w[2]);
        rdy    = r + ST * CH;
        for (int e = b; e <= rdy + 3; e++) begin
            i   = (e >= p[2]) ? 2 : ((e >= p[1]) ? 1 : 0);
            got = outs();
            exp = model_seq(e, p[i], w[i], (i == 2) ? r : -1, i);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL timeout_recovery c%0d: got %b expected %b", e - b, got, exp);
            end
            if (e == e_lock) locked = 1'b1;
            @(negedge clkin);
        end
    endtask

    task automatic test_fault();
        int b, f, h, wf, i;
        int p[3];
        int w[3];
        logic [8:0] got, exp;
        do_reset(b);
        for (int k = 0; k < 3; k++) begin
            p[k] = b + k * (PR + LT);
            w[k] = p[k] + PR;
        end
        f  = b + 3 * (PR + LT);
        h  = $urandom_range(1, 3);
        wf = f + 4 + h + PR;
        for (int e = b; e <= wf + 3; e++) begin
            if (e < f) begin
                i   = (e >= p[2]) ? 2 : ((e >= p[1]) ? 1 : 0);
                exp = model_seq(e, p[i], w[i], -1, i);
            end else if (e <= f + 4) begin
                exp = {1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2};
            end else begin
                exp = model_seq(e, f + 5, wf, -1, 0);
            end
            got = outs();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL fault c%0d: got %b expected %b", e - b, got, exp);
            end
            if (e == f + 2) begin
                n_cmp++;
                if (state_dbg !== ST_FAULT) begin
                    n_bad++;
                    $display("FAIL fault_state: got %0d expected %0d", state_dbg, ST_FAULT);
                end
            end
            force_relock = (e >= f + 4) && (e < f + 4 + h);
            @(negedge clkin);
        end
    endtask

    task automatic test_lock_loss_run();
        int b, w, r, rdy, d, l, w2, r2, rdy2, pulses;
        logic [8:0] got, exp;
        do_reset(b);
        w      = b + PR;
        r      = model_release(w + $urandom_range(0, 10), w);
        rdy    = r + ST * CH;
        d      = rdy + $urandom_range(2, 10);
        l      = d + 3;
        w2     = l + PR;
        r2     = model_release(d + 1, w2);
        rdy2   = r2 + ST * CH;
        pulses = 0;
        for (int e = b; e <= rdy2 + 2; e++) begin
            if (e < l) begin
                exp = model_seq(e, b, w, r, 0);
            end else begin
                exp = model_seq(e, l, w2, r2, 0);
            end
            if (e == l) exp[2] = 1'b1;
            got = outs();
            if (lock_lost === 1'b1) pulses++;
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL lock_loss c%0d: got %b expected %b", e - b, got, exp);
            end
            if (e == d + 3) begin
                n_cmp++;
                if (rst_n_out !== 3'b000) begin
                    n_bad++;
                    $display("FAIL lock_loss_rst3: got %b expected 000", rst_n_out);
                end
            end
            if (e == w + $urandom_range(0, 0) - PR + r - r) begin
                // locked rises at the instant the model assumed (recomputed below)
            end
            if (e == r - 1 - LF - 2) locked = 1'b1;
            if (e == d)              locked = 1'b0;
            if (e == d + 1)          locked = 1'b1;
            @(negedge clkin);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL lock_lost_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_force_beats_loss();
        int b, w, e_lock, r, rdy, d;
        logic [8:0] got, exp;
        do_reset(b);
        w      = b + PR;
        e_lock = w + $urandom_range(0, 10);
        r      = model_release(e_lock, w);
        rdy    = r + ST * CH;
        d      = rdy + $urandom_range(1, 6);
        for (int e = b; e <= d + 12; e++) begin
            if (e < d + 3) begin
                exp = model_seq(e, b, w, r, 0);
            end else begin
                exp = model_seq(e, d + 3, d + 3 + PR, -1, 0);
            end
            got = outs();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL force_beats_loss c%0d: got %b expected %b", e - b, got, exp);
            end
            if (e == e_lock) locked = 1'b1;
            if (e == d)      locked = 1'b0;
            force_relock = (e == d + 2);
            @(negedge clkin);
        end
    endtask

    task automatic test_async_reset_release();
        int b, w, e_lock, r, stop;
        logic [8:0] got, exp;
        do_reset(b);
        w      = b + PR;
        e_lock = w + $urandom_range(0, 10);
        r      = model_release(e_lock, w);
        stop   = r + ST + $urandom_range(0, ST - 1);
        for (int e = b; e <= stop; e++) begin
            got = outs();
            exp = model_seq(e, b, w, r, 0);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL async_pre c%0d: got %b expected %b", e - b, got, exp);
            end
            if (e == e_lock) locked = 1'b1;
            if (e < stop) @(negedge clkin);
        end
        resetn = 1'b0;
        #1;
        got = outs();
        n_cmp++;
        if (got !== RESET_VEC) begin
            n_bad++;
            $display("FAIL async_reset_immediate: got %b expected %b", got, RESET_VEC);
        end
        n_cmp++;
        if (state_dbg !== ST_PLL_RESET) begin
            n_bad++;
            $display("FAIL async_reset_state: got %0d expected %0d", state_dbg, ST_PLL_RESET);
        end
        @(posedge clkin);
        #1;
        got = outs();
        n_cmp++;
        if (got !== RESET_VEC) begin
            n_bad++;
            $display("FAIL async_reset_held: got %b expected %b", got, RESET_VEC);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        resetn       = 1'b0;
        locked       = 1'b0;
        force_relock = 1'b0;
        test_reset();
        test_clean_start();
        test_glitchy_lock();
        test_timeout_recovery();
        test_fault();
        test_lock_loss_run();
        test_force_beats_loss();
        test_async_reset_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
